// File: rtl/aes_pkg.sv
// Shared AES datapath constants and column helpers.
// The ShiftRows column reader imports this same package.
package aes_pkg;

  localparam int STATE_W   = 128;
  localparam int COL_W     = 32;
  localparam int BYTE_W    = 8;
  localparam int NB        = 4;
  localparam int NUM_BANKS = 2;

  typedef logic [1:0] col_idx_t;

  // Column 0 sits in the most significant 32 bits of the state.
  function automatic int unsigned col_lsb(col_idx_t c);
    return 32'(96 - 32 * int'(c));
  endfunction

endpackage

// File: rtl/col_assembler_if.sv
// Column-in / state-out handshake bundle for the column assembler.
// The slave modport is the assembler; the master modport is its environment.
interface col_assembler_if;
  import aes_pkg::*;

  logic [BYTE_W-1:0]  in_1_col;
  logic [BYTE_W-1:0]  in_2_col;
  logic [BYTE_W-1:0]  in_3_col;
  logic [BYTE_W-1:0]  in_4_col;
  logic               in_valid;
  logic               in_ready;
  logic               flush;
  col_idx_t           wr_col;
  logic [STATE_W-1:0] state_out;
  logic               out_valid;
  logic               out_ready;
  logic [3:0]         states_done;

  modport slave (
    input  in_1_col, in_2_col, in_3_col, in_4_col, in_valid, flush, out_ready,
    output in_ready, wr_col, state_out, out_valid, states_done
  );

  modport master (
    output in_1_col, in_2_col, in_3_col, in_4_col, in_valid, flush, out_ready,
    input  in_ready, wr_col, state_out, out_valid, states_done
  );
endinterface

// File: rtl/col_bank.sv
// One 128-bit state buffer written a column at a time, with its full flag.
// Set and clear never target the same bank in one cycle (write needs empty, release needs full).
module col_bank
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  col_idx_t           col,
  input  logic [COL_W-1:0]   col_data,
  input  logic               set_full,
  input  logic               clr_full,
  output logic [STATE_W-1:0] data,
  output logic               full
);

  logic [COL_W-1:0] cols [NB];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  // NOTE: the data array is reset on purpose; state_out must read as zero
  // straight after reset, so this storage cannot be left uninitialised.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NB; i++) cols[i] <= '0;
      full <= 1'b0;
    end else begin
      if (wr_en) cols[col] <= col_data;
      if (set_full)      full <= 1'b1;
      else if (clr_full) full <= 1'b0;
    end
  end

  assign data = {cols[0], cols[1], cols[2], cols[3]};

endmodule

// File: rtl/col_assembler.sv
// Ping-pong assembler: four 32-bit columns per AES state, two state banks so
// the reader drains one state while the next is being written.
module col_assembler
  import aes_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  col_assembler_if.slave  bus
);

  logic                 wr_bank;
  logic                 rd_bank;
  col_idx_t             wr_col_q;
  logic [3:0]           done_cnt;

  logic [NUM_BANKS-1:0] full;
  logic [NUM_BANKS-1:0] wr_en;
  logic [NUM_BANKS-1:0] set_full;
  logic [NUM_BANKS-1:0] clr_full;
  logic [STATE_W-1:0]   bank_data [NUM_BANKS];
  logic [COL_W-1:0]     col_data;
  logic                 accept;
  logic                 release_state;
  logic                 last_col;

  assign col_data      = {bus.in_1_col, bus.in_2_col, bus.in_3_col, bus.in_4_col};
  assign bus.in_ready  = !full[wr_bank];
  // Flush takes precedence: a column offered alongside it is dropped.
  assign accept        = bus.in_valid && !full[wr_bank] && !bus.flush;
  assign release_state = full[rd_bank] && bus.out_ready;
  assign last_col      = (wr_col_q == col_idx_t'(NB - 1));

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign wr_en[b]    = accept && (wr_bank == 1'(b));
    assign set_full[b] = wr_en[b] && last_col;
    assign clr_full[b] = release_state && (rd_bank == 1'(b));

    col_bank u_bank (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en[b]),
      .col      (wr_col_q),
      .col_data (col_data),
      .set_full (set_full[b]),
      .clr_full (clr_full[b]),
      .data     (bank_data[b]),
      .full     (full[b])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      wr_col_q <= '0;
      done_cnt <= '0;
    end else begin
      if (bus.flush) begin
        wr_col_q <= '0;
      end else if (accept) begin
        wr_col_q <= col_idx_t'(wr_col_q + 2'd1);
        if (last_col) wr_bank <= ~wr_bank;
      end
      if (release_state) begin
        rd_bank  <= ~rd_bank;
        done_cnt <= done_cnt + 4'd1;
      end
    end
  end

  // A half-written bank never shows: visibility follows the full flags only.
  assign bus.out_valid   = full[rd_bank];
  assign bus.state_out   = bank_data[rd_bank];
  assign bus.wr_col      = wr_col_q;
  assign bus.states_done = done_cnt;

endmodule

// File: doc/col_assembler.md
Name: col_assembler

Overview:
- Writer-side counterpart of the ShiftRows column reader.
- Accepts one 32-bit state column per handshake (four bytes from the MixColumns/AddRoundKey path) and reassembles four columns into a 128-bit AES state.
- Double-buffered (ping-pong): the downstream column reader can consume state N while state N+1 is being written.

Parameters:
- NUM_BANKS, 2, number of 128-bit state buffers; fixed at 2 (ping-pong).
- STATE_W, 128, AES state width.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- in_1_col  input  8  column byte 0 (row 0, most significant byte of the column).
- in_2_col  input  8  column byte 1 (row 1).
- in_3_col  input  8  column byte 2 (row 2).
- in_4_col  input  8  column byte 3 (row 3).
- in_valid  input  1  input column present.
- in_ready  output  1  assembler can accept a column.
- flush  input  1  discard the partially written state in the current write bank.
- wr_col  output  2  column index the next accepted column is written to (0..3).
- state_out  output  128  completed state from the read bank.
- out_valid  output  1  state_out holds a complete, unconsumed state.
- out_ready  input  1  consumer takes state_out.
- states_done  output  4  count of states delivered; wraps 15 -> 0.

Behaviour:
- Column placement: column c occupies state bits [127-32c : 96-32c]. in_1_col goes to [127-32c : 120-32c], in_4_col to [103-32c : 96-32c]. This matches the reader's first-round (unshifted) column order.
- Per bank state: 128-bit data and a full flag. Pointers: wr_bank, rd_bank (1 bit each), wr_col (2 bits).
- in_ready = !full[wr_bank]. Combinational; no dependence on in_valid.
- Accept (in_valid && in_ready && !flush):
  - write the four bytes into column wr_col of bank wr_bank; wr_col increments.
  - if wr_col was 3: set full[wr_bank], toggle wr_bank, wr_col returns to 0.
  - latency: out_valid rises the cycle after the 4th column is accepted.
- out_valid = full[rd_bank]; state_out = data[rd_bank].
- Release (out_valid && out_ready): clear full[rd_bank], toggle rd_bank, states_done increments. in_ready may rise the next cycle.
- Simultaneous accept and release on different banks: both take effect in the same cycle. Sustained throughput is one column per cycle with no bubble while out_ready is held high.
- Both banks full: in_ready=0, input stalls, no data overwritten. in_valid while in_ready=0 has no effect.
- flush:
  - wr_col <= 0; current write-bank data is left stale and overwritten later.
  - full flags, rd_bank and the read side are untouched.
  - flush wins over a same-cycle accept; the column is dropped.
  - flush on a full write bank has no effect beyond wr_col <= 0.
- Partially written bank is never visible: out_valid depends only on full flags.
- reset (synchronous, highest priority, valid mid-transfer):
  - data zeroed, full flags 0, wr_bank=rd_bank=0, wr_col=0, states_done=0.
  - out_valid=0, state_out=0, in_ready=1 from the first cycle after reset.
- Registers update on the rising edge of clk only; no latches. Outputs derived combinationally from registered state, so no in-to-out combinational paths except none (in_ready depends on registers only).
- Parameter values other than the defaults are not supported.

Decomposition:
- Shared package aes_pkg: STATE_W=128, COL_W=32, BYTE_W=8, NB=4 (columns), col_idx_t (2-bit column index type), function col_lsb(c) returning 96-32c. The column reader uses the same package.
- Optional sub-module col_bank: one 128-bit bank with column write-enable and full flag, instantiated twice. Pointer and handshake logic stay in the top.

Test Plan:
- After reset, four columns 00112233, 44556677, 8899aabb, ccddeeff with out_ready=1 -> out_valid in cycle 5, state_out=00112233_44556677_8899aabb_ccddeeff, states_done=1.
- out_ready=0, eight columns back-to-back -> both banks fill, in_ready=0 after the 8th. A 9th column is held off. Raising out_ready delivers state A then state B in order; in_ready returns the cycle after the first release.
- Continuous streaming, out_ready=1, 16 states -> one column accepted every cycle, no in_ready drop, states_done wraps to 0.
- Two columns written, then flush asserted with in_valid=1 and column deadbeef -> column dropped, wr_col=0. The next four columns form a state with no trace of deadbeef or the earlier two columns.
- reset asserted after three columns with one full bank pending -> next cycle out_valid=0, state_out=0, wr_col=0, in_ready=1, states_done=0.
- Byte-lane check: column c=2 with bytes a1,b2,c3,d4 -> state_out[63:56]=a1, [55:48]=b2, [47:40]=c3, [39:32]=d4.
